// File: rtl/fifo_word_packer_if.sv
// Handshake bundle between the FIFO pop side, the word packer and the wide-bus writer.
// The slave modport is the packer's view; master is the surrounding environment.
interface fifo_word_packer_if #(
  parameter int DATA_WIDTH = 8,
  parameter int PACK_RATIO = 4,
  parameter int CNT_WIDTH  = 3
);
  logic                             in_valid;
  logic                             in_ready;
  logic [DATA_WIDTH-1:0]            in_data;
  logic                             flush;
  logic                             out_valid;
  logic                             out_ready;
  logic [DATA_WIDTH*PACK_RATIO-1:0] out_data;
  logic [PACK_RATIO-1:0]            out_keep;
  logic [CNT_WIDTH-1:0]             out_count;
  logic                             busy;

  modport master (
    output in_valid, in_data, flush, out_ready,
    input  in_ready, out_valid, out_data, out_keep, out_count, busy
  );

  modport slave (
    input  in_valid, in_data, flush, out_ready,
    output in_ready, out_valid, out_data, out_keep, out_count, busy
  );
endinterface

// File: rtl/fifo_word_packer.sv
// Packs PACK_RATIO narrow FIFO beats into one wide word held in a one-entry
// valid/ready output register; flush closes a partial word early.
module fifo_word_packer #(
  parameter int DATA_WIDTH = 8,
  parameter int PACK_RATIO = 4,
  parameter int CNT_WIDTH  = 3
) (
  input logic               clk,
  input logic               rst,
  fifo_word_packer_if.slave bus
);
  localparam int OUT_W = DATA_WIDTH * PACK_RATIO;
  localparam logic [CNT_WIDTH-1:0] FULL_CNT = CNT_WIDTH'(PACK_RATIO);

  typedef logic [PACK_RATIO-1:0][DATA_WIDTH-1:0] lane_t;
  typedef enum logic {EMPTY, FULL} out_state_t;

  function automatic logic [PACK_RATIO-1:0] keep_mask(input logic [CNT_WIDTH-1:0] cnt);
    logic [PACK_RATIO-1:0] m;
    m = '0;
    for (int i = 0; i < PACK_RATIO; i++) m[i] = (CNT_WIDTH'(i) < cnt);
    return m;
  endfunction

  function automatic logic [OUT_W-1:0] mask_lanes(input lane_t lanes,
                                                  input logic [CNT_WIDTH-1:0] cnt);
    logic [OUT_W-1:0] w;
    w = '0;
    for (int i = 0; i < PACK_RATIO; i++)
      if (CNT_WIDTH'(i) < cnt) w[i*DATA_WIDTH +: DATA_WIDTH] = lanes[i];
    return w;
  endfunction

  lane_t                 acc_lane_p0;
  logic [CNT_WIDTH-1:0]  acc_count_p0;
  logic [OUT_W-1:0]      out_data_p1;
  logic [PACK_RATIO-1:0] out_keep_p1;
  logic [CNT_WIDTH-1:0]  out_count_p1;
  out_state_t            state_q, state_d;
  logic                  vld_p1;
  logic                  acc_full, slot_free, xfer, in_ready, accept;

  assign vld_p1    = (state_q == FULL);
  assign acc_full  = (acc_count_p0 == FULL_CNT);
  assign slot_free = !vld_p1 || bus.out_ready;
  // Flush only closes beats already held; a beat arriving alongside starts the next word.
  assign xfer      = slot_free && (acc_full || (bus.flush && (acc_count_p0 != '0)));
  assign in_ready  = !acc_full || xfer;
  assign accept    = bus.in_valid && in_ready;

  // Stage p0: accumulator
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_lane_p0  <= '0;
      acc_count_p0 <= '0;
    end else if (accept) begin
      if (xfer) begin
        acc_lane_p0[0] <= bus.in_data;
        acc_count_p0   <= CNT_WIDTH'(1);
      end else begin
        for (int i = 0; i < PACK_RATIO; i++)
          if (CNT_WIDTH'(i) == acc_count_p0) acc_lane_p0[i] <= bus.in_data;
        acc_count_p0 <= acc_count_p0 + CNT_WIDTH'(1);
      end
    end else if (xfer) begin
      acc_count_p0 <= '0;
    end
  end

  // Stage p1: output register and its occupancy state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= EMPTY;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY:   if (xfer) state_d = FULL;
      FULL:    if (bus.out_ready && !xfer) state_d = EMPTY;
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_data_p1  <= '0;
      out_keep_p1  <= '0;
      out_count_p1 <= '0;
    end else if (xfer) begin
      out_data_p1  <= mask_lanes(acc_lane_p0, acc_count_p0);
      out_keep_p1  <= keep_mask(acc_count_p0);
      out_count_p1 <= acc_count_p0;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = vld_p1;
  assign bus.out_data  = out_data_p1;
  assign bus.out_keep  = out_keep_p1;
  assign bus.out_count = out_count_p1;
  assign bus.busy      = (acc_count_p0 != '0) || vld_p1;
endmodule
